sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO for same-domain buffering between QAM stack stages
//  (symbol mapper -> modulator datapath), used where no clock crossing exists.

---
 rtl/sync_fifo_param.sv | 124 ++++++++++++
 tb/tb_sync_fifo_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  clear_errors,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [CntW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            afull_q, afull_d;
  logic            aempty_q, aempty_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_acc, rd_acc;

  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  // Acceptance uses the registered flags, so full+read frees no slot for the write.
  always_comb begin
    wr_acc      = write_enable & ~full_q;
    rd_acc      = read_enable & ~empty_q;
    wr_ptr_d    = wr_ptr_q + CntW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + CntW'(rd_acc);
    // Extra wrap bit makes the pointer difference the exact fill, including Depth.
    count_d     = wr_ptr_d - rd_ptr_d;
    full_d      = (count_d == CntW'(Depth));
    empty_d     = (count_d == '0);
    afull_d     = (count_d >= CntW'(AF_THRESH));
    aempty_d    = (count_d <= CntW'(AE_THRESH));
    // Setting wins over clear_errors in the same cycle.
    overflow_d  = (write_enable & full_q) | (overflow_q & ~clear_errors);
    underflow_d = (read_enable & empty_q) | (underflow_q & ~clear_errors);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_addr] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; forced to zero while nothing is stored.
  always_comb begin
    data_out = '0;
    if (!empty_q) begin
      data_out = mem_q[rd_addr];
    end
  end
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem_q[rd_addr];
    end
  end

  assign data_out = data_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign fill_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int unsigned DW    = 10;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          write_enable, read_enable, clear_errors;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   fill_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .clear_errors(clear_errors),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fill_count  (fill_count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare everything.
  task automatic step(input bit we, input bit re, input bit clr, input bit rs,
                      input logic [DW-1:0] din);
    int n;
    bit was_full, was_empty;
    write_enable = we;
    read_enable  = re;
    clear_errors = clr;
    rst          = rs;
    data_in      = din;
    @(posedge clk);
    #1;
    n = model_q.size();
    if (rs) begin
      model_q.delete();
      m_ov   = 1'b0;
      m_un   = 1'b0;
      m_dout = '0;
    end else begin
      was_full  = (n == DEPTH);
      was_empty = (n == 0);
      if (re && !was_empty) m_dout = model_q.pop_front();
      if (we && !was_full) model_q.push_back(din);
      m_ov = (we && was_full) || (m_ov && !clr);
      m_un = (re && was_empty) || (m_un && !clr);
    end
    n = model_q.size();
    chk("fill_count", 32'(fill_count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_FWFT_EN
    if (n != 0) chk("data_out_fwft", 32'(data_out), 32'(model_q[0]));
`else
    chk("data_out", 32'(data_out), 32'(m_dout));
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic reset2();
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0;
    write_enable = 1'b0;
    read_enable = 1'b0;
    clear_errors = 1'b0;

    // Reset values
    reset2();
    chk("reset_data_out_zero", 32'(data_out), 32'h0);

    // Fill 0x001..0x010, one overflowing write, then drain in order
    for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
    chk("full_after_fill", 32'(full), 32'h1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Underflow on empty after reset, then clear
    reset2();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("underflow_set", 32'(underflow), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("underflow_cleared", 32'(underflow), 32'h0);

    // Steady simultaneous traffic at fill 8, wrapping pointers
    reset2();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
    chk("steady_count", 32'(fill_count), 32'd8);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Full + simultaneous, empty + simultaneous
    reset2();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i + 'h40));
    step(1'b1, 1'b1, 1'b0, 1'b0, DW'('h3ff));
    chk("full_rw_count", 32'(fill_count), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, DW'('h155));
    chk("empty_rw_count", 32'(fill_count), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Reset mid-burst with 9 words stored; new data only afterwards
    reset2();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i + 'h80));
    step(1'b1, 1'b1, 1'b0, 1'b1, DW'('h99));
    chk("midreset_count", 32'(fill_count), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i + 'h300));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b1 && ($urandom_range(0, 99) < 55), 1'b1 && ($urandom_range(0, 99) < 50),
           1'b1 && ($urandom_range(0, 15) == 0), 1'b1 && ($urandom_range(0, 99) == 0),
           DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
